// File: rtl/reset_seq.sv
// Reset sequencer: holds all domain resets low, waits for lock,
// then releases them one by one in ascending index order.
module reset_seq #(
  parameter int N_OUT          = 4,
  parameter int ASSERT_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             req,
  input  logic             locked,
  output logic             req_ack,
  output logic [N_OUT-1:0] aresetn_out,
  output logic             busy,
  output logic             done
);

  localparam int MAXC = (ASSERT_CYCLES > STAGGER_CYCLES) ?
                        ASSERT_CYCLES : STAGGER_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(N_OUT + 1);

  localparam logic [CW-1:0] A_LAST = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOCK,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] rstn_q, rstn_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req || !locked) begin
          state_d = S_ASSERT;
          rstn_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          ack_d   = req;
        end
      end
      S_ASSERT: begin
        if (cnt_q == A_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          rstn_d[0] = 1'b1;
          cnt_d     = '0;
          if (N_OUT == 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IW'(1);
          end
        end
      end
      S_RELEASE: begin
        if (req || !locked) begin
          state_d = S_ASSERT;
          rstn_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          ack_d   = req;
        end else if (cnt_q == S_LAST) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (idx_q == IW'(i)) rstn_d[i] = 1'b1;
          end
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_q == I_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // A request here is already covered by the sequence just finished.
        if (!locked) begin
          state_d = S_ASSERT;
          rstn_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_ASSERT;
        rstn_d  = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign req_ack     = ack_q;
  assign aresetn_out = rstn_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default build plus a minimal
// N_OUT=1 / 1-cycle build sharing the clock.
module tb_reset_seq;

  logic       aclk;
  logic       areset, req, locked;
  logic       req_ack, busy, done;
  logic [3:0] aresetn_out;

  logic       areset2, req2, locked2;
  logic       req_ack2, busy2, done2;
  logic [0:0] aresetn_out2;

  int errs = 0;
  int checks = 0;

  reset_seq #(
    .N_OUT(4), .ASSERT_CYCLES(16), .STAGGER_CYCLES(8)
  ) dut (
    .aclk(aclk), .areset(areset), .req(req), .locked(locked),
    .req_ack(req_ack), .aresetn_out(aresetn_out),
    .busy(busy), .done(done)
  );

  reset_seq #(
    .N_OUT(1), .ASSERT_CYCLES(1), .STAGGER_CYCLES(1)
  ) dut1 (
    .aclk(aclk), .areset(areset2), .req(req2), .locked(locked2),
    .req_ack(req_ack2), .aresetn_out(aresetn_out2),
    .busy(busy2), .done(done2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Edges 1..42 after the edge that started the sequence (lock held).
  task automatic seq_check(input string tag, input int hold);
    logic [3:0] exp;
    for (int e = 1; e <= 42; e++) begin
      req = (e <= hold);
      tick();
      exp = 4'b0000;
      for (int i = 0; i < 4; i++)
        if (e >= 17 + 8 * i) exp[i] = 1'b1;
      chk({tag, "_rstn"}, 32'(aresetn_out), 32'(exp));
      chk({tag, "_done"}, 32'(done), 32'(e == 41));
      chk({tag, "_busy"}, 32'(busy), 32'(e < 42));
      chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    end
    req = 1'b0;
  endtask

  task automatic accept_req(input string tag);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk({tag, "_ack"}, 32'(req_ack), 32'd1);
    chk({tag, "_rstn0"}, 32'(aresetn_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int n;
    int dones;
    areset  = 1'b1; req  = 1'b0; locked  = 1'b1;
    areset2 = 1'b1; req2 = 1'b0; locked2 = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("por_rstn", 32'(aresetn_out), 32'd0);
      chk("por_busy", 32'(busy), 32'd1);
      chk("por_done", 32'(done), 32'd0);
      chk("por_ack", 32'(req_ack), 32'd0);
    end
    areset  = 1'b0;
    areset2 = 1'b0;
    seq_check("por", 0);

    accept_req("req");
    seq_check("req", 0);

    accept_req("lk");
    tick();
    tick();
    locked = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("lk_hold", 32'(aresetn_out), 32'd0);
    end
    locked = 1'b1;
    tick();
    chk("lk_bit0", 32'(aresetn_out), 32'h1);
    n = 0;
    dones = 0;
    while (busy && n < 100) begin
      tick();
      if (done) dones++;
      n++;
    end
    chk("lk_idle", 32'(busy), 32'd0);
    chk("lk_dones", 32'(dones), 32'd1);
    chk("lk_rstn", 32'(aresetn_out), 32'hF);

    accept_req("ab");
    for (int i = 0; i < 26; i++) tick();
    chk("ab_pre", 32'(aresetn_out), 32'h3);
    req = 1'b1;
    tick();
    chk("ab_rstn", 32'(aresetn_out), 32'd0);
    chk("ab_ack", 32'(req_ack), 32'd1);
    seq_check("ab", 15);

    locked = 1'b0;
    tick();
    locked = 1'b1;
    chk("il_rstn", 32'(aresetn_out), 32'd0);
    chk("il_ack", 32'(req_ack), 32'd0);
    chk("il_busy", 32'(busy), 32'd1);
    seq_check("il", 0);

    accept_req("rl");
    for (int i = 0; i < 33; i++) tick();
    chk("rl_pre", 32'(aresetn_out), 32'h7);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    chk("rl_rstn", 32'(aresetn_out), 32'd0);
    chk("rl_ack", 32'(req_ack), 32'd0);
    seq_check("rl", 0);

    accept_req("ar");
    for (int i = 0; i < 30; i++) tick();
    chk("ar_pre", 32'(aresetn_out), 32'h3);
    areset = 1'b1;
    req = 1'b1;
    tick();
    areset = 1'b0;
    req = 1'b0;
    chk("ar_rstn", 32'(aresetn_out), 32'd0);
    chk("ar_busy", 32'(busy), 32'd1);
    chk("ar_ack", 32'(req_ack), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    seq_check("ar", 0);

    chk("n1_idle", 32'(busy2), 32'd0);
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    chk("n1_ack", 32'(req_ack2), 32'd1);
    chk("n1_rstn0", 32'(aresetn_out2), 32'd0);
    tick();
    chk("n1_k1_rstn", 32'(aresetn_out2), 32'd0);
    chk("n1_k1_done", 32'(done2), 32'd0);
    chk("n1_k1_ack", 32'(req_ack2), 32'd0);
    tick();
    chk("n1_k2_rstn", 32'(aresetn_out2), 32'd1);
    chk("n1_k2_done", 32'(done2), 32'd1);
    chk("n1_k2_busy", 32'(busy2), 32'd1);
    tick();
    chk("n1_k3_busy", 32'(busy2), 32'd0);
    chk("n1_k3_done", 32'(done2), 32'd0);
    chk("n1_k3_rstn", 32'(aresetn_out2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Single-clock reset sequencer that generates the active-low reset bundle consumed by the per-domain reset synchronizers in the VILLAS FPGA design. It starts a reset cycle on power-up, on a software request, or when the clock source loses lock. It holds every output low for a minimum width, then waits for `locked`. It then releases the outputs one at a time in ascending index order with a fixed stagger, so interconnect comes out of reset before the IP cores behind it. A request/acknowledge pair and `busy`/`done` flags let the AXI-Lite register block trigger and observe the sequence.

## Interface
- `N_OUT`, 4: number of reset outputs; ≥ 1.
- `ASSERT_CYCLES`, 16: minimum cycles all outputs are held low in ASSERT; ≥ 1.
- `STAGGER_CYCLES`, 8: cycles between consecutive output releases; ≥ 1.

Ports:
- `aclk` in 1: the single clock.
- `areset` in 1: synchronous, active-high reset.
- `req` in 1: reset request, sampled each rising edge, level-sensitive.
- `locked` in 1: clock-source lock, already synchronous to `aclk`.
- `req_ack` out 1: one-cycle pulse when `req` is accepted.
- `aresetn_out` out N_OUT: active-low resets; bit 0 is released first.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: high for exactly one cycle at the end of the sequence.

## Operation
- States: IDLE, ASSERT, WAIT_LOCK, RELEASE, DONE. Counter `cnt` is sized to `clog2(max(ASSERT_CYCLES, STAGGER_CYCLES)+1)`. Index `idx` is sized to `clog2(N_OUT+1)`. All outputs are registered.
- `areset`=1 at an edge sets:
  - state = ASSERT, `cnt`=0, `idx`=0
  - `aresetn_out`=0 (all bits), `busy`=1, `req_ack`=0, `done`=0
  - This means a power-on sequence runs automatically once `areset` falls.
- IDLE: `aresetn_out` is all ones.
  - `req`=1 or `locked`=0 → ASSERT, with `aresetn_out`=0 and `cnt`=0.
  - `req_ack`=1 for that cycle only when `req` caused the transition.
- ASSERT: `cnt` increments each cycle. When `cnt`=ASSERT_CYCLES-1 → WAIT_LOCK.
- WAIT_LOCK: stays until `locked`=1. Then → RELEASE, with `aresetn_out[0]`=1, `idx`=1, `cnt`=0.
- RELEASE:
  - `cnt` increments each cycle.
  - When `cnt`=STAGGER_CYCLES-1: set `aresetn_out[idx]`=1, increment `idx`, clear `cnt`.
  - Releasing bit N_OUT-1 → DONE.
  - With N_OUT=1: WAIT_LOCK → DONE directly, releasing bit 0 on the same edge.
- DONE: `done`=1 for this single cycle, then → IDLE.
- Request handling by state:
  - `req`=1 in ASSERT, WAIT_LOCK or DONE: ignored and not acknowledged. The sequence in flight satisfies it. A `req` still high in IDLE starts a new sequence.
  - `req`=1 in RELEASE: abort. Go to ASSERT, set `aresetn_out`=0 (all bits), `cnt`=0, `idx`=0, `req_ack`=1.
- Lock loss by state:
  - `locked`=0 in RELEASE or DONE: same abort as above, but `req_ack`=0.
  - `locked`=0 in ASSERT: no effect; WAIT_LOCK gates the release.
- `req` and `locked`=0 together in IDLE or RELEASE: take the `req` action, with `req_ack`=1.
- `areset` has priority over every other input.
- Invariants:
  - No bit ever goes from 0 to 1 except in WAIT_LOCK or RELEASE.
  - Bits are released in ascending index order.
  - All bits fall together, on one edge.

## Timing
- Let edge k be the edge at which a request is accepted in IDLE, and assume `locked`=1:
  - `aresetn_out` is 0 after edge k.
  - State is WAIT_LOCK after edge k+ASSERT_CYCLES.
  - Bit i is released after edge k+ASSERT_CYCLES+1+i·STAGGER_CYCLES.
  - `done` is high in the cycle after the last release.
  - State is IDLE after the following edge.
- Defaults: last release at k+41, `done` high between edges k+41 and k+42.
- Power-on: same timing, with k replaced by the last edge at which `areset`=1.
- `aresetn_out` holds the low state for at least ASSERT_CYCLES+1 cycles.
- `req_ack` has zero-cycle latency: it is asserted after the same edge that accepts `req`.

## Test plan
- Defaults, `locked`=1, `areset` high for 3 cycles then low → all outputs 0 during reset; bits 0..3 rise at edges r+17, r+25, r+33, r+41; `done` is a single pulse at r+41; `busy` falls after r+42.
- In IDLE, `req`=1 for 1 cycle → `req_ack` one-cycle pulse and `aresetn_out`=4'b0000 on the same edge; `aresetn_out`=4'b0001 at k+17; `done` at k+41.
- `locked`=0 during ASSERT and held low 50 cycles → outputs stay 0 through WAIT_LOCK; bit 0 rises one edge after `locked` returns to 1.
- `req` pulsed when `aresetn_out`=4'b0011 (RELEASE) → all bits 0 on the next edge, `req_ack`=1, full 16-cycle ASSERT restarts; `req` held high through ASSERT → no second `req_ack`.
- `locked` dropped in IDLE → outputs go to 0, `req_ack` stays 0, sequence reruns; same test with `areset` asserted mid-RELEASE → state and outputs match the reset values exactly.
- N_OUT=1, ASSERT_CYCLES=1, STAGGER_CYCLES=1 → bit 0 and `done` both asserted at edge k+2; IDLE at k+3.
